// File: rtl/stream_normalizer_arbiter.sv
// Packet-granular round-robin arbiter feeding one StreamNormalizer from N_SRC AXI4S producers.
// Grant is held from first beat through the accepted tlast; o_src carries the granted index as sideband.
module stream_normalizer_arbiter #(
  parameter  int unsigned WIDTH    = 512,
  parameter  int unsigned N_SRC    = 4,
  localparam int unsigned SRC_BITS = $clog2(N_SRC)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_SRC*WIDTH-1:0]    s_tdata,
  input  logic [N_SRC*WIDTH/8-1:0]  s_tkeep,
  input  logic [N_SRC-1:0]          s_tlast,
  input  logic [N_SRC-1:0]          s_tvalid,
  output logic [N_SRC-1:0]          s_tready,
  output logic [WIDTH-1:0]          m_tdata,
  output logic [WIDTH/8-1:0]        m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [SRC_BITS-1:0]       o_src,
  input  logic                      i_pause,
  output logic                      o_busy
);

  localparam int unsigned KW = WIDTH / 8;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t              r_state, w_state_nxt;
  logic [SRC_BITS-1:0] r_grant_idx, w_grant_nxt;
  logic [SRC_BITS-1:0] r_rr_ptr, w_rr_nxt;
  logic [SRC_BITS-1:0] w_pick;
  logic                w_pick_vld;
  logic [WIDTH-1:0]    w_data;
  logic [KW-1:0]       w_keep;
  logic                w_last;
  logic                w_valid;
  logic                w_drop;
  logic                w_grant;
  logic                w_pkt_end;

  // Source mux is driven by the registered grant index only, so m_t* never sees m_tready.
  always_comb begin
    w_data  = '0;
    w_keep  = '0;
    w_last  = 1'b0;
    w_valid = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (r_grant_idx == SRC_BITS'(i)) begin
        w_data  = s_tdata[i*WIDTH +: WIDTH];
        w_keep  = s_tkeep[i*KW +: KW];
        w_last  = s_tlast[i];
        w_valid = s_tvalid[i];
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    int unsigned         idx;
    logic [SRC_BITS-1:0] w_i;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(r_rr_ptr) + k) % N_SRC;
      w_i = SRC_BITS'(idx);
      if (!w_pick_vld && s_tvalid[w_i]) begin
        w_pick     = w_i;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_grant   = (r_state == GRANT);
  assign w_drop    = w_valid && (w_keep == '0) && !w_last;
  assign m_tdata   = w_data;
  assign m_tkeep   = w_keep;
  assign m_tlast   = w_last;
  assign m_tvalid  = w_grant && w_valid && !w_drop;
  assign w_pkt_end = m_tvalid && m_tready && m_tlast;
  assign o_busy    = w_grant;
  assign o_src     = r_grant_idx;

  // Dropped zero-keep beats are drained from the source regardless of downstream ready.
  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      s_tready[i] = w_grant && (r_grant_idx == SRC_BITS'(i)) && (m_tready || w_drop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_idx;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (!i_pause && w_pick_vld) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick;
        end
      end
      GRANT: begin
        if (w_pkt_end) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (r_grant_idx == SRC_BITS'(N_SRC - 1)) ? '0 : r_grant_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

endmodule
